arp_cache_ctrl: RTL and testbench
=================================

// Module: arp_cache_ctrl
// PURPOSE
//  Parametrised ARP control engine between the arp_rx/arp_tx datapaths and user logic. Keeps a
//  CACHE_DEPTH-entry IP->MAC cache learned from received ARP packets. Answers ARP requests
//  automatically and resolves user lookups, issuing ARP requests with timeout and retry on a miss.
// PARAMETERS
//  CACHE_DEPTH  4            cache entries, >=2, power of two
//  RETRY_MAX    3            ARP requests sent per resolution before failure, 1..15
//  TIMEOUT_CYC  125_000_000  cycles to wait for a reply after each request (1 s @125 MHz)
//  AGE_CYC      125_000_000  aging tick period (used only with ARP_AGING_EN)
// PORTS
//  i_gmii_clk         in   1   single clock, all logic
//  i_rst              in   1   synchronous, active-high reset
//  i_arp_rx_done      in   1   one-cycle pulse: ARP packet received, fields valid
//  i_arp_rx_type      in   1   0 = request, 1 = reply
//  i_arp_srcmac_addr  in   48  sender MAC of the received packet
//  i_arp_srcip_addr   in   32  sender IP of the received packet
//  i_lookup_req       in   1   one-cycle pulse: resolve i_lookup_ip
//  i_lookup_ip        in   32  IP to resolve
//  o_lookup_ack       out  1   one-cycle pulse, exactly 1 cycle after i_lookup_req
//  o_lookup_hit       out  1   valid with ack: 1 = found in cache
//  o_lookup_mac       out  48  valid with ack when hit, else 0
//  o_resolve_done     out  1   pulse: pending resolution completed; MAC now cached
//  o_resolve_fail     out  1   pulse: RETRY_MAX requests sent with no reply
//  o_arp_tx_en        out  1   one-cycle pulse to arp_tx
//  o_arp_tx_type      out  1   0 = request, 1 = reply; held until i_arp_tx_done
//  o_arp_desmac_addr  out  48  target MAC; held until i_arp_tx_done
//  o_arp_desip_addr   out  32  target IP; held until i_arp_tx_done
//  i_arp_tx_done      in   1   one-cycle pulse from arp_tx at frame end
//  o_cache_count      out  $clog2(CACHE_DEPTH)+1  number of valid entries
// BEHAVIOUR
//  Reset: all entries invalid, victim pointer 0, FSM IDLE, all outputs 0.
//  Learn (cycle after i_arp_rx_done): IP match -> overwrite MAC. Else first invalid slot, lowest
//   index first. Else slot at the round-robin victim pointer, which then advances and wraps.
//  Lookup: registered compare of all entries; ack/hit/mac appear the cycle after the req and
//   see cache contents from before any learn in the same cycle.
//  Miss with FSM IDLE and no resolution pending: latch IP, start resolution, retry count = 0.
//   Miss while a resolution is pending: ack, hit = 0, no new resolution.
//  Reply pending: set on a received request. Latch sender MAC/IP; a newer request overwrites
//   the latched values until the reply is issued.
//  FSM: IDLE -> TX_REPLY if reply pending (priority), else TX_REQ if resolution needs a send.
//   TX_REPLY/TX_REQ: drive fields, pulse o_arp_tx_en for 1 cycle, go to WAIT_DONE.
//   WAIT_DONE: on i_arp_tx_done return to IDLE; clear reply pending, or, after TX_REQ, increment
//    retry count and load the timeout counter with TIMEOUT_CYC.
//  Request frame: type 0, des MAC = 48'hFF_FF_FF_FF_FF_FF, des IP = latched IP.
//  Reply frame: type 1, des MAC/IP = latched sender MAC/IP.
//  Timeout counts down only while resolution pending and not transmitting. At 0:
//   retry < RETRY_MAX -> resend; else pulse o_resolve_fail and clear the resolution.
//  Learning the pending IP (either rx type) clears the resolution and pulses o_resolve_done
//   in the same cycle as the learn; this wins over a timeout in the same cycle.
//  Requests for the board IP are filtered by arp_rx; every rx_done is treated as valid.
//  Reset mid-transmit: FSM returns to IDLE immediately; an in-flight i_arp_tx_done is ignored.
// CONFIGURATION
//  ARP_AGING_EN defined: each entry has a 2-bit age counter, cleared on learn or lookup hit.
//   Every AGE_CYC cycles all valid ages increment; an entry at age 3 is invalidated on the
//   next tick, and o_cache_count drops.
//  Undefined: no tick counter, no age state; entries persist until replaced or reset.
// STRUCTURE
//  arp_pkg: FSM state encoding, ARP_OP_REQ = 1'b0 / ARP_OP_REPLY = 1'b1, BCAST_MAC constant.
//  Sub-module arp_cache_mem: valid/IP/MAC (and age) arrays, parallel match, free-slot
//   priority encoder, victim pointer. The top holds the FSM, timeout and retry counters.
// TESTING
//  (use TIMEOUT_CYC = 100, AGE_CYC = 50 in the bench)
//  rx request from 192.168.1.102 / 00-0A-0B-0C-0D-0E -> one tx_en, type 1, des fields as sent;
//   cache_count = 1.
//  lookup 192.168.1.102 after learn -> ack next cycle, hit = 1, mac = 00-0A-0B-0C-0D-0E.
//  lookup 192.168.1.50 on empty cache -> hit = 0; tx type 0, MAC all-F; rx reply from .50
//   -> resolve_done, then lookup hits.
//  miss with no reply, RETRY_MAX = 3 -> exactly 3 requests 100 cycles apart, then one
//   resolve_fail pulse.
//  learn 5 distinct IPs with DEPTH = 4 -> the 5th replaces slot 0; count stays 4.
//  rx request arriving while a TX_REQ frame is in WAIT_DONE -> reply sent right after
//   tx_done, before any retry.
//  ARP_AGING_EN: learn one entry, no hits for 4 ticks -> count returns to 0.

Source files
------------

// File: rtl/arp_cache_ctrl_pkg.sv
// Shared ARP types for the cache controller: FSM states, opcodes and the broadcast MAC.
package arp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_TX_REPLY  = 2'd1,
    ST_TX_REQ    = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arp_state_e;

  localparam logic        ARP_OP_REQ   = 1'b0;
  localparam logic        ARP_OP_REPLY = 1'b1;
  localparam logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/arp_cache_ctrl_if.sv
// Transmit handshake between the ARP cache controller (master) and the arp_tx datapath (slave).
interface arp_tx_if;
  logic        o_arp_tx_en;
  logic        o_arp_tx_type;
  logic [47:0] o_arp_desmac_addr;
  logic [31:0] o_arp_desip_addr;
  logic        i_arp_tx_done;

  modport master (
    output o_arp_tx_en, o_arp_tx_type, o_arp_desmac_addr, o_arp_desip_addr,
    input  i_arp_tx_done
  );

  modport slave (
    input  o_arp_tx_en, o_arp_tx_type, o_arp_desmac_addr, o_arp_desip_addr,
    output i_arp_tx_done
  );
endinterface

// File: rtl/arp_cache_mem.sv
// IP->MAC cache storage: parallel match, lowest-free-slot allocation, round-robin replacement.
// Optional per-entry aging is enabled with the ARP_AGING_EN macro.
module arp_cache_mem #(
  parameter int DEPTH   = 4
`ifdef ARP_AGING_EN
  ,
  parameter int AGE_CYC = 125_000_000
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     learn_en,
  input  logic [31:0]              learn_ip,
  input  logic [47:0]              learn_mac,
  input  logic [31:0]              lookup_ip,
`ifdef ARP_AGING_EN
  input  logic                     lookup_touch,
`endif
  output logic                     lookup_hit,
  output logic [47:0]              lookup_mac,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [31:0]      ip_q  [DEPTH];
  logic [31:0]      ip_d  [DEPTH];
  logic [47:0]      mac_q [DEPTH];
  logic [47:0]      mac_d [DEPTH];
  logic [IDX_W-1:0] victim_q, victim_d;

  logic             lk_hit, ln_hit, free_found;
  logic [IDX_W-1:0] lk_idx, ln_idx, free_idx, wr_idx;

`ifdef ARP_AGING_EN
  localparam int ACW = (AGE_CYC > 1) ? $clog2(AGE_CYC) : 1;
  logic [1:0]     age_q [DEPTH];
  logic [1:0]     age_d [DEPTH];
  logic [ACW-1:0] age_cnt_q, age_cnt_d;
  logic           tick;
`endif

  always_comb begin
    lk_hit     = 1'b0;
    lk_idx     = '0;
    ln_hit     = 1'b0;
    ln_idx     = '0;
    free_found = 1'b0;
    free_idx   = '0;
    count      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && ip_q[i] == lookup_ip) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (valid_q[i] && ip_q[i] == learn_ip) begin
        ln_hit = 1'b1;
        ln_idx = IDX_W'(i);
      end
      count = count + CNT_W'(valid_q[i]);
    end
    // Scan downwards so the lowest free index is the one left standing.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    lookup_hit = lk_hit;
    lookup_mac = lk_hit ? mac_q[lk_idx] : '0;
    wr_idx     = ln_hit ? ln_idx : (free_found ? free_idx : victim_q);
  end

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    valid_d  = valid_q;
    ip_d     = ip_q;
    mac_d    = mac_q;
    victim_d = victim_q;
`ifdef ARP_AGING_EN
    age_d     = age_q;
    tick      = (age_cnt_q == ACW'(AGE_CYC - 1));
    age_cnt_d = tick ? '0 : age_cnt_q + ACW'(1);
    for (int i = 0; i < DEPTH; i++) begin
      if (tick && valid_q[i]) begin
        if (age_q[i] == 2'd3) valid_d[i] = 1'b0;
        else                  age_d[i]   = age_q[i] + 2'd1;
      end
    end
    if (lookup_touch && lk_hit) begin
      valid_d[lk_idx] = 1'b1;
      age_d[lk_idx]   = 2'd0;
    end
`endif
    if (learn_en) begin
      valid_d[wr_idx] = 1'b1;
      ip_d[wr_idx]    = learn_ip;
      mac_d[wr_idx]   = learn_mac;
`ifdef ARP_AGING_EN
      age_d[wr_idx]   = 2'd0;
`endif
      if (!ln_hit && !free_found) victim_d = victim_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      victim_q  <= '0;
`ifdef ARP_AGING_EN
      age_cnt_q <= '0;
`endif
    end else begin
      valid_q   <= valid_d;
      victim_q  <= victim_d;
`ifdef ARP_AGING_EN
      age_cnt_q <= age_cnt_d;
`endif
    end
  end

  // NOTE: payload arrays are not reset; valid_q gates every read and each learn rewrites the slot.
  always_ff @(posedge clk) begin
    ip_q  <= ip_d;
    mac_q <= mac_d;
`ifdef ARP_AGING_EN
    age_q <= age_d;
`endif
  end

endmodule

// File: rtl/arp_cache_ctrl.sv
// ARP control engine: learns an IP->MAC cache, answers requests, resolves lookups with retry.
// Define ARP_AGING_EN to age out entries that see no learn or lookup hit.
module arp_cache_ctrl
  import arp_pkg::*;
#(
  parameter int CACHE_DEPTH = 4,
  parameter int RETRY_MAX   = 3,
  parameter int TIMEOUT_CYC = 125_000_000,
  parameter int AGE_CYC     = 125_000_000
) (
  input  logic                         i_gmii_clk,
  input  logic                         i_rst,
  input  logic                         i_arp_rx_done,
  input  logic                         i_arp_rx_type,
  input  logic [47:0]                  i_arp_srcmac_addr,
  input  logic [31:0]                  i_arp_srcip_addr,
  input  logic                         i_lookup_req,
  input  logic [31:0]                  i_lookup_ip,
  output logic                         o_lookup_ack,
  output logic                         o_lookup_hit,
  output logic [47:0]                  o_lookup_mac,
  output logic                         o_resolve_done,
  output logic                         o_resolve_fail,
  arp_tx_if.master                     tx,
  output logic [$clog2(CACHE_DEPTH):0] o_cache_count
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  arp_state_e  state_q, state_d;
  logic        tx_en_q, tx_en_d, tx_type_q, tx_type_d;
  logic [47:0] desmac_q, desmac_d;
  logic [31:0] desip_q, desip_d;
  logic        sending_req_q, sending_req_d;

  logic        reply_pend_q, reply_pend_d;
  logic [47:0] reply_mac_q, reply_mac_d;
  logic [31:0] reply_ip_q, reply_ip_d;

  logic             res_pend_q, res_pend_d, need_send_q, need_send_d;
  logic [31:0]      res_ip_q, res_ip_d;
  logic [3:0]       retry_q, retry_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic        ack_q, ack_d, hit_q, hit_d, done_q, done_d, fail_q, fail_d;
  logic [47:0] lmac_q, lmac_d;

  logic        mem_hit;
  logic [47:0] mem_mac;

  arp_cache_mem #(
    .DEPTH   (CACHE_DEPTH)
`ifdef ARP_AGING_EN
    ,
    .AGE_CYC (AGE_CYC)
`endif
  ) u_mem (
    .clk          (i_gmii_clk),
    .rst          (i_rst),
    .learn_en     (i_arp_rx_done),
    .learn_ip     (i_arp_srcip_addr),
    .learn_mac    (i_arp_srcmac_addr),
    .lookup_ip    (i_lookup_ip),
`ifdef ARP_AGING_EN
    .lookup_touch (i_lookup_req),
`endif
    .lookup_hit   (mem_hit),
    .lookup_mac   (mem_mac),
    .count        (o_cache_count)
  );

  always_comb begin
    state_d       = state_q;
    tx_en_d       = 1'b0;
    tx_type_d     = tx_type_q;
    desmac_d      = desmac_q;
    desip_d       = desip_q;
    sending_req_d = sending_req_q;
    reply_pend_d  = reply_pend_q;
    reply_mac_d   = reply_mac_q;
    reply_ip_d    = reply_ip_q;
    res_pend_d    = res_pend_q;
    res_ip_d      = res_ip_q;
    need_send_d   = need_send_q;
    retry_d       = retry_q;
    tmo_d         = tmo_q;
    done_d        = 1'b0;
    fail_d        = 1'b0;
    ack_d         = i_lookup_req;
    hit_d         = i_lookup_req & mem_hit;
    lmac_d        = hit_d ? mem_mac : '0;

    case (state_q)
      ST_IDLE: begin
        if (reply_pend_q)                   state_d = ST_TX_REPLY;
        else if (res_pend_q && need_send_q) state_d = ST_TX_REQ;
      end
      ST_TX_REPLY: begin
        tx_en_d       = 1'b1;
        tx_type_d     = ARP_OP_REPLY;
        desmac_d      = reply_mac_q;
        desip_d       = reply_ip_q;
        sending_req_d = 1'b0;
        state_d       = ST_WAIT_DONE;
      end
      ST_TX_REQ: begin
        tx_en_d       = 1'b1;
        tx_type_d     = ARP_OP_REQ;
        desmac_d      = BCAST_MAC;
        desip_d       = res_ip_q;
        sending_req_d = 1'b1;
        need_send_d   = 1'b0;
        state_d       = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tx.i_arp_tx_done) begin
          state_d = ST_IDLE;
          if (sending_req_q) begin
            retry_d = retry_q + 4'd1;
            tmo_d   = TMO_W'(TIMEOUT_CYC);
          end else begin
            reply_pend_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The reply timer only runs between frames, once the last request has gone out.
    if (state_q == ST_IDLE && res_pend_q && !need_send_q) begin
      if (tmo_q != '0) begin
        tmo_d = tmo_q - TMO_W'(1);
      end else if (retry_q < 4'(RETRY_MAX)) begin
        need_send_d = 1'b1;
      end else begin
        fail_d     = 1'b1;
        res_pend_d = 1'b0;
      end
    end

    if (i_lookup_req && !mem_hit && state_q == ST_IDLE && !res_pend_q) begin
      res_pend_d  = 1'b1;
      res_ip_d    = i_lookup_ip;
      retry_d     = 4'd0;
      need_send_d = 1'b1;
    end

    // Hearing from the pending IP resolves it, overriding a timeout decided this cycle.
    if (i_arp_rx_done && res_pend_q && i_arp_srcip_addr == res_ip_q) begin
      res_pend_d  = 1'b0;
      need_send_d = 1'b0;
      fail_d      = 1'b0;
      done_d      = 1'b1;
    end

    if (i_arp_rx_done && i_arp_rx_type == ARP_OP_REQ) begin
      reply_pend_d = 1'b1;
      reply_mac_d  = i_arp_srcmac_addr;
      reply_ip_d   = i_arp_srcip_addr;
    end
  end

  always_ff @(posedge i_gmii_clk) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      tx_en_q       <= 1'b0;
      tx_type_q     <= 1'b0;
      desmac_q      <= '0;
      desip_q       <= '0;
      sending_req_q <= 1'b0;
      reply_pend_q  <= 1'b0;
      reply_mac_q   <= '0;
      reply_ip_q    <= '0;
      res_pend_q    <= 1'b0;
      res_ip_q      <= '0;
      need_send_q   <= 1'b0;
      retry_q       <= '0;
      tmo_q         <= '0;
      ack_q         <= 1'b0;
      hit_q         <= 1'b0;
      lmac_q        <= '0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_en_q       <= tx_en_d;
      tx_type_q     <= tx_type_d;
      desmac_q      <= desmac_d;
      desip_q       <= desip_d;
      sending_req_q <= sending_req_d;
      reply_pend_q  <= reply_pend_d;
      reply_mac_q   <= reply_mac_d;
      reply_ip_q    <= reply_ip_d;
      res_pend_q    <= res_pend_d;
      res_ip_q      <= res_ip_d;
      need_send_q   <= need_send_d;
      retry_q       <= retry_d;
      tmo_q         <= tmo_d;
      ack_q         <= ack_d;
      hit_q         <= hit_d;
      lmac_q        <= lmac_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
    end
  end

  assign tx.o_arp_tx_en       = tx_en_q;
  assign tx.o_arp_tx_type     = tx_type_q;
  assign tx.o_arp_desmac_addr = desmac_q;
  assign tx.o_arp_desip_addr  = desip_q;
  assign o_lookup_ack         = ack_q;
  assign o_lookup_hit         = hit_q;
  assign o_lookup_mac         = lmac_q;
  assign o_resolve_done       = done_q;
  assign o_resolve_fail       = fail_q;

endmodule

// File: tb/tb_arp_cache_ctrl.sv
// Directed bench for arp_cache_ctrl; a small arp_tx stand-in answers each frame 3 cycles later.
// With ARP_AGING_EN defined it runs the aging sequence instead of the default-build sequence.
module tb_arp_cache_ctrl;
  import arp_pkg::*;

  localparam int DEPTH = 4;
  localparam int RMAX  = 3;
  localparam int TMO   = 100;
  localparam int AGE   = 50;

  localparam logic [31:0] IP_A  = 32'hC0A8_0166;  // 192.168.1.102
  localparam logic [47:0] MAC_A = 48'h000A_0B0C_0D0E;
  localparam logic [31:0] IP_B  = 32'hC0A8_0132;  // 192.168.1.50
  localparam logic [47:0] MAC_B = 48'h0011_2233_4455;
  localparam logic [31:0] IP_C  = 32'hC0A8_014D;
  localparam logic [31:0] IP_D0 = 32'hC0A8_01C9;
  localparam logic [31:0] IP_D1 = 32'hC0A8_01CA;
  localparam logic [31:0] IP_D2 = 32'hC0A8_01CB;
  localparam logic [47:0] MAC_D2 = 48'hD2D2_D2D2_D2D2;
  localparam logic [31:0] IP_E  = 32'hC0A8_0158;
  localparam logic [47:0] MAC_E = 48'h00EE_EEEE_EE01;
  localparam logic [47:0] MAC_A2 = 48'h00AA_AAAA_AA02;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_done, rx_type, lookup_req;
  logic [47:0] rx_mac;
  logic [31:0] rx_ip, lookup_ip;
  logic        lookup_ack, lookup_hit, resolve_done, resolve_fail;
  logic [47:0] lookup_mac;
  logic [$clog2(DEPTH):0] cache_count;

  arp_tx_if tx_if ();

  arp_cache_ctrl #(
    .CACHE_DEPTH (DEPTH),
    .RETRY_MAX   (RMAX),
    .TIMEOUT_CYC (TMO),
    .AGE_CYC     (AGE)
  ) dut (
    .i_gmii_clk        (clk),
    .i_rst             (rst),
    .i_arp_rx_done     (rx_done),
    .i_arp_rx_type     (rx_type),
    .i_arp_srcmac_addr (rx_mac),
    .i_arp_srcip_addr  (rx_ip),
    .i_lookup_req      (lookup_req),
    .i_lookup_ip       (lookup_ip),
    .o_lookup_ack      (lookup_ack),
    .o_lookup_hit      (lookup_hit),
    .o_lookup_mac      (lookup_mac),
    .o_resolve_done    (resolve_done),
    .o_resolve_fail    (resolve_fail),
    .tx                (tx_if),
    .o_cache_count     (cache_count)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        typ;
    logic [47:0] mac;
    logic [31:0] ip;
  } tx_rec_t;

  tx_rec_t tx_q[$];
  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int fail_cnt = 0;
  int fail_cyc = 0;

  // Cycle stamp and frame/fail log, sampled just after each rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    #2;
    if (tx_if.o_arp_tx_en)
      tx_q.push_back('{cyc, tx_if.o_arp_tx_type, tx_if.o_arp_desmac_addr, tx_if.o_arp_desip_addr});
    if (resolve_fail) begin
      fail_cnt++;
      fail_cyc = cyc;
    end
  end

  initial begin
    tx_if.i_arp_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_if.o_arp_tx_en) begin
        repeat (3) @(negedge clk);
        tx_if.i_arp_tx_done = 1'b1;
        @(negedge clk);
        tx_if.i_arp_tx_done = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rx(input logic typ, input logic [47:0] mac, input logic [31:0] ip);
    rx_done = 1'b1;
    rx_type = typ;
    rx_mac  = mac;
    rx_ip   = ip;
    tick(1);
    rx_done = 1'b0;
  endtask

  // Returns on the cycle the ack is expected.
  task automatic lookup(input logic [31:0] ip);
    lookup_req = 1'b1;
    lookup_ip  = ip;
    tick(1);
    lookup_req = 1'b0;
  endtask

  task automatic wait_tx(input int n, input string tag);
    int b = 0;
    while (tx_q.size() < n && b < 2000) begin
      tick(1);
      b++;
    end
    check(tag, 64'(tx_q.size()), 64'(n));
  endtask

  initial begin
    int k;
    int t;
    int b;
    rst        = 1'b1;
    rx_done    = 1'b0;
    rx_type    = 1'b0;
    rx_mac     = '0;
    rx_ip      = '0;
    lookup_req = 1'b0;
    lookup_ip  = '0;
    tick(3);
    check("rst_count",  64'(cache_count), 64'(0));
    check("rst_tx_en",  64'(tx_if.o_arp_tx_en), 64'(0));
    check("rst_desmac", 64'(tx_if.o_arp_desmac_addr), 64'(0));
    check("rst_ack",    64'(lookup_ack), 64'(0));
    check("rst_done",   64'(resolve_done), 64'(0));
    check("rst_fail",   64'(resolve_fail), 64'(0));
    rst = 1'b0;
    tick(2);

`ifdef ARP_AGING_EN
    rx(ARP_OP_REPLY, MAC_A, IP_A);
    tick(1);
    rx(ARP_OP_REPLY, MAC_B, IP_B);
    check("age_count2", 64'(cache_count), 64'(2));
    for (int i = 0; i < 8; i++) begin
      tick(39);
      lookup(IP_A);
      check("age_keep_hit", 64'(lookup_hit), 64'(1));
    end
    check("age_b_expired", 64'(cache_count), 64'(1));
    tick(260);
    check("age_all_expired", 64'(cache_count), 64'(0));
    check("age_no_tx", 64'(tx_q.size()), 64'(0));
`else
    // Received request: learn it and reply to the sender.
    k = cyc;
    rx(ARP_OP_REQ, MAC_A, IP_A);
    wait_tx(1, "reply_sent");
    check("reply_type",  64'(tx_q[0].typ), 64'(ARP_OP_REPLY));
    check("reply_mac",   64'(tx_q[0].mac), 64'(MAC_A));
    check("reply_ip",    64'(tx_q[0].ip),  64'(IP_A));
    check("reply_cycle", 64'(tx_q[0].cyc), 64'(k + 3));
    check("count_1",     64'(cache_count), 64'(1));
    tick(10);
    check("reply_once",  64'(tx_q.size()), 64'(1));
    check("reply_held",  64'(tx_if.o_arp_desip_addr), 64'(IP_A));

    lookup(IP_A);
    check("lk_a_ack", 64'(lookup_ack), 64'(1));
    check("lk_a_hit", 64'(lookup_hit), 64'(1));
    check("lk_a_mac", 64'(lookup_mac), 64'(MAC_A));
    tick(1);
    check("lk_a_ack_pulse", 64'(lookup_ack), 64'(0));

    // Miss starts a resolution, answered by a reply.
    k = cyc;
    lookup(IP_B);
    check("lk_b_ack", 64'(lookup_ack), 64'(1));
    check("lk_b_hit", 64'(lookup_hit), 64'(0));
    check("lk_b_mac", 64'(lookup_mac), 64'(0));
    wait_tx(2, "req_b_sent");
    check("req_b_type",  64'(tx_q[1].typ), 64'(ARP_OP_REQ));
    check("req_b_mac",   64'(tx_q[1].mac), 64'(BCAST_MAC));
    check("req_b_ip",    64'(tx_q[1].ip),  64'(IP_B));
    check("req_b_cycle", 64'(tx_q[1].cyc), 64'(k + 3));
    tick(10);
    rx(ARP_OP_REPLY, MAC_B, IP_B);
    check("res_b_done", 64'(resolve_done), 64'(1));
    tick(1);
    check("res_b_done_pulse", 64'(resolve_done), 64'(0));
    check("count_2", 64'(cache_count), 64'(2));
    lookup(IP_B);
    check("lk_b2_hit", 64'(lookup_hit), 64'(1));
    check("lk_b2_mac", 64'(lookup_mac), 64'(MAC_B));
    tick(5);
    check("no_reply_to_reply", 64'(tx_q.size()), 64'(2));

    // Unanswered miss: three requests, then one failure pulse.
    lookup(IP_C);
    check("lk_c_hit", 64'(lookup_hit), 64'(0));
    b = 0;
    while (fail_cnt < 1 && b < 1000) begin
      tick(1);
      b++;
    end
    check("fail_seen",    64'(fail_cnt), 64'(1));
    check("retry_frames", 64'(tx_q.size()), 64'(5));
    check("retry_ip",     64'(tx_q[4].ip), 64'(IP_C));
    check("retry_type",   64'(tx_q[4].typ), 64'(ARP_OP_REQ));
    check("retry_gap1",   64'(tx_q[3].cyc - tx_q[2].cyc), 64'(107));
    check("retry_gap2",   64'(tx_q[4].cyc - tx_q[3].cyc), 64'(107));
    check("fail_gap",     64'(fail_cyc - tx_q[4].cyc), 64'(105));
    tick(150);
    check("no_more_frames", 64'(tx_q.size()), 64'(5));
    check("fail_once",      64'(fail_cnt), 64'(1));

    // Fill the cache, then the fifth IP evicts slot 0 (IP_A).
    rx(ARP_OP_REPLY, 48'hD0D0_D0D0_D0D0, IP_D0);
    tick(1);
    rx(ARP_OP_REPLY, 48'hD1D1_D1D1_D1D1, IP_D1);
    tick(1);
    check("count_full", 64'(cache_count), 64'(4));
    rx(ARP_OP_REPLY, MAC_D2, IP_D2);
    tick(1);
    check("count_stays_4", 64'(cache_count), 64'(4));
    lookup(IP_D2);
    check("lk_d2_hit", 64'(lookup_hit), 64'(1));
    check("lk_d2_mac", 64'(lookup_mac), 64'(MAC_D2));
    lookup(IP_B);
    check("lk_b_kept", 64'(lookup_hit), 64'(1));
    tick(1);
    lookup(IP_A);
    check("lk_a_evicted", 64'(lookup_hit), 64'(0));

    // Request for IP_A goes out; a request arrives while it is in flight.
    b = 0;
    while (!tx_if.o_arp_tx_en && b < 50) begin
      tick(1);
      b++;
    end
    check("req_a_tx_en", 64'(tx_if.o_arp_tx_en), 64'(1));
    t = cyc;
    check("req_a_ip", 64'(tx_q[5].ip), 64'(IP_A));
    tick(1);
    rx(ARP_OP_REQ, MAC_E, IP_E);
    wait_tx(7, "reply_e_sent");
    check("reply_e_type",  64'(tx_q[6].typ), 64'(ARP_OP_REPLY));
    check("reply_e_ip",    64'(tx_q[6].ip),  64'(IP_E));
    check("reply_e_mac",   64'(tx_q[6].mac), 64'(MAC_E));
    check("reply_e_cycle", 64'(tx_q[6].cyc), 64'(t + 6));
    tick(10);
    rx(ARP_OP_REPLY, MAC_A2, IP_A);
    check("res_a_done", 64'(resolve_done), 64'(1));
    tick(1);
    lookup(IP_A);
    check("lk_a2_hit", 64'(lookup_hit), 64'(1));
    check("lk_a2_mac", 64'(lookup_mac), 64'(MAC_A2));
    lookup(IP_E);
    check("lk_e_hit", 64'(lookup_hit), 64'(1));
    check("count_end", 64'(cache_count), 64'(4));
    tick(150);
    check("no_retry_after_done", 64'(tx_q.size()), 64'(7));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
